fifo_controller_width_conversion: RTL and testbench

//   Pointer/flag controller for a FIFO whose write port is twice the width of its read port.

---
 rtl/fifo_controller_width_conversion_if.sv | 22 ++
 rtl/fifo_controller_width_conversion.sv | 40 ++++
 tb/tb_fifo_controller_width_conversion.sv | 90 +++++++++
 3 files changed

// File: rtl/fifo_controller_width_conversion_if.sv
// fifo_controller_width_conversion_if: request/flag/address bundle between FIFO user and controller
//   write_i, read_i              user -> controller requests
//   empty_o, full_o              controller -> user occupancy flags
//   write_address_1_o/_2_o       RAM write addresses for the low/high half of a wide word
//   read_address_o               RAM address of the oldest narrow word
interface fifo_controller_width_conversion_if #(parameter int ADDR_WIDTH = 4);
   logic                  write_i;
   logic                  read_i;
   logic                  empty_o;
   logic                  full_o;
   logic [ADDR_WIDTH-1:0] write_address_1_o;
   logic [ADDR_WIDTH-1:0] write_address_2_o;
   logic [ADDR_WIDTH-1:0] read_address_o;
   modport master (
      output write_i, read_i,
      input  empty_o, full_o, write_address_1_o, write_address_2_o, read_address_o
   );
   modport slave (
      input  write_i, read_i,
      output empty_o, full_o, write_address_1_o, write_address_2_o, read_address_o
   );
endinterface

// File: rtl/fifo_controller_width_conversion.sv
// fifo_controller_width_conversion: pointer/flag controller for a FIFO with a 2x-wide write port
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-low reset
//   bus      slave side of the request/flag/address bundle
module fifo_controller_width_conversion #(
   parameter int ADDR_WIDTH = 4
) (
   input logic                              clk_i,
   input logic                              reset_i,
   fifo_controller_width_conversion_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   logic [ADDR_WIDTH-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  wr_ok, rd_ok;
   // a single free slot cannot hold a wide word, so DEPTH-1 already counts as full
   assign bus.full_o            = count_q > (ADDR_WIDTH+1)'(DEPTH - 2);
   assign bus.empty_o           = count_q == '0;
   assign bus.write_address_1_o = wptr_q;
   assign bus.write_address_2_o = wptr_q + ADDR_WIDTH'(1);
   assign bus.read_address_o    = rptr_q;
   always_comb begin
      wr_ok   = bus.write_i & ~bus.full_o;
      rd_ok   = bus.read_i & ~bus.empty_o;
      wptr_d  = wr_ok ? wptr_q + ADDR_WIDTH'(2) : wptr_q;
      rptr_d  = rd_ok ? rptr_q + ADDR_WIDTH'(1) : rptr_q;
      count_d = count_q + (wr_ok ? (ADDR_WIDTH+1)'(2) : '0) - (rd_ok ? (ADDR_WIDTH+1)'(1) : '0);
   end
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
endmodule

// File: tb/tb_fifo_controller_width_conversion.sv
// tb_fifo_controller_width_conversion: directed self-checking bench for the width-converting FIFO controller
module tb_fifo_controller_width_conversion;
   logic clk_i;
   logic reset_i;
   int   checks;
   int   errors;
   int   m_w, m_r, m_c;
   fifo_controller_width_conversion_if #(.ADDR_WIDTH(4)) bus();
   fifo_controller_width_conversion #(.ADDR_WIDTH(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .bus     (bus)
   );
   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic chk_all(input string tag);
      chk({tag, " empty"}, int'(bus.empty_o), int'(m_c == 0));
      chk({tag, " full"}, int'(bus.full_o), int'(m_c > 14));
      chk({tag, " addr1"}, int'(bus.write_address_1_o), m_w % 16);
      chk({tag, " addr2"}, int'(bus.write_address_2_o), (m_w + 1) % 16);
      chk({tag, " raddr"}, int'(bus.read_address_o), m_r % 16);
   endtask
   task automatic chk_reset(input string tag);
      chk({tag, " empty"}, int'(bus.empty_o), 1);
      chk({tag, " full"}, int'(bus.full_o), 0);
      chk({tag, " addr1"}, int'(bus.write_address_1_o), 0);
      chk({tag, " addr2"}, int'(bus.write_address_2_o), 1);
      chk({tag, " raddr"}, int'(bus.read_address_o), 0);
   endtask
   task automatic cyc(input logic w, input logic r, input string tag);
      bit wok, rok;
      bus.write_i = w;
      bus.read_i  = r;
      @(posedge clk_i);
      wok = w && !(m_c > 14);
      rok = r && (m_c != 0);
      if (wok) m_w += 2;
      if (rok) m_r += 1;
      m_c += (wok ? 2 : 0) - (rok ? 1 : 0);
      @(negedge clk_i);
      chk_all(tag);
   endtask
   initial begin
      checks = 0; errors = 0;
      m_w = 0; m_r = 0; m_c = 0;
      bus.write_i = 1'b0;
      bus.read_i  = 1'b0;
      reset_i     = 1'b0;
      repeat (2) @(negedge clk_i);
      chk_reset("in_reset");
      reset_i = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, "idle");
      repeat (3) cyc(1'b1, 1'b0, "write3");
      chk("after_write3 addr1", int'(bus.write_address_1_o), 6);
      chk("after_write3 addr2", int'(bus.write_address_2_o), 7);
      chk("after_write3 empty", int'(bus.empty_o), 0);
      repeat (6) cyc(1'b0, 1'b1, "read6");
      chk("after_read6 empty", int'(bus.empty_o), 1);
      chk("after_read6 raddr", int'(bus.read_address_o), 6);
      repeat (3) cyc(1'b0, 1'b1, "read_empty");
      chk("read_empty raddr", int'(bus.read_address_o), 6);
      repeat (20) cyc(1'b1, 1'b0, "write20");
      chk("fill full", int'(bus.full_o), 1);
      chk("fill addr1", int'(bus.write_address_1_o), 6);
      repeat (16) cyc(1'b1, 1'b1, "both16");
      chk("both16 raddr", int'(bus.read_address_o), 6);
      chk("both16 addr1", int'(bus.write_address_1_o), 4);
      chk("both16 full", int'(bus.full_o), 0);
      chk("both16 empty", int'(bus.empty_o), 0);
      bus.write_i = 1'b1;
      bus.read_i  = 1'b1;
      #2 reset_i = 1'b0;
      #1 chk_reset("async_reset");
      m_w = 0; m_r = 0; m_c = 0;
      @(negedge clk_i);
      chk_reset("held_reset");
      reset_i = 1'b1;
      cyc(1'b1, 1'b0, "post_reset_write");
      chk("post_reset addr1", int'(bus.write_address_1_o), 2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
